spike_rate_counter: RTL and testbench

SPIKE_RATE_COUNTER -- requirements
Module: spike_rate_counter

---
 rtl/spike_cnt_pkg.sv | 17 +
 rtl/spike_edge_sync.sv | 40 ++++
 rtl/spike_rate_counter.sv | 120 ++++++++++++
 tb/tb_spike_rate_counter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spike_cnt_pkg.sv
// ---------------------------------------------------------------------------
// spike_cnt_pkg
// Shared defaults for the spike rate counter and a helper that sizes the
// window timer from the window length.
// ---------------------------------------------------------------------------
package spike_cnt_pkg;

  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_CNT_W      = 32;
  localparam int DEF_WIN_CYCLES = 200000;  // 1 ms at 200 MHz

  // Bits needed to hold timer values 0..win_cycles-1 (win_cycles >= 2).
  function automatic int timer_width(input int win_cycles);
    return (win_cycles < 2) ? 1 : $clog2(win_cycles);
  endfunction

endpackage

// File: rtl/spike_edge_sync.sv
// ---------------------------------------------------------------------------
// spike_edge_sync
// Two-flop synchronizer for one asynchronous spike line followed by a
// registered rising-edge detector. A 0->1 transition first sampled on clock
// edge N produces a one-cycle edge_pulse that is consumed on edge N+3.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   spike_async  raw asynchronous spike input
//   edge_pulse   one-cycle pulse per synchronized rising edge
// ---------------------------------------------------------------------------
module spike_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic spike_async,
  output logic edge_pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q     <= 1'b0;
      sync_q     <= 1'b0;
      prev_q     <= 1'b0;
      edge_pulse <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what builds the pipeline here.
      meta_q     <= spike_async;
      sync_q     <= meta_q;
      prev_q     <= sync_q;
      edge_pulse <= sync_q & ~prev_q;
    end
  end

endmodule

// File: rtl/spike_rate_counter.sv
// ---------------------------------------------------------------------------
// spike_rate_counter
// Counts rising edges on NUM_CH asynchronous spike lines over fixed windows
// of WIN_CYCLES enabled clock cycles and publishes each completed window's
// counts with a one-cycle cnt_valid strobe.
//
// Optional feature macro: SPIKE_CNT_SAT_EN
//   defined   -> accumulators saturate at 2^CNT_W-1, ovf reports saturation
//   undefined -> accumulators wrap modulo 2^CNT_W, ovf stays 0
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   en           1: timer and counting run, 0: counting state freezes
//   clear        synchronous restart of the current window
//   spike        NUM_CH asynchronous spike lines
//   int_cnt_out  last completed window's counts, channel k at [k*CNT_W +: CNT_W]
//   cnt_valid    one-cycle pulse when int_cnt_out takes a new value
//   ovf          per-channel overflow of the last completed window
// ---------------------------------------------------------------------------
module spike_rate_counter
  import spike_cnt_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int WIN_CYCLES = DEF_WIN_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    clear,
  input  logic [NUM_CH-1:0]       spike,
  output logic [NUM_CH*CNT_W-1:0] int_cnt_out,
  output logic                    cnt_valid,
  output logic [NUM_CH-1:0]       ovf
);

  localparam int               TMR_W    = timer_width(WIN_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WIN_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
`ifdef SPIKE_CNT_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
`endif

  logic [NUM_CH-1:0] edge_det;
  logic [TMR_W-1:0]  timer_q;
  logic [CNT_W-1:0]  acc_q   [NUM_CH];
  logic [CNT_W-1:0]  acc_sum [NUM_CH];  // acc plus this cycle's edge
  logic [NUM_CH-1:0] sat_hit;           // edge arrived at the saturation value
  logic [NUM_CH-1:0] ovf_q;             // overflow seen in the running window

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    spike_edge_sync u_sync (
      .clk         (clk),
      .reset       (reset),
      .spike_async (spike[k]),
      .edge_pulse  (edge_det[k])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a value before any condition,
    // so no path can leave it unassigned and imply a latch.
    sat_hit = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      acc_sum[k] = acc_q[k];
      if (edge_det[k]) begin
`ifdef SPIKE_CNT_SAT_EN
        if (acc_q[k] == CNT_MAX) begin
          sat_hit[k] = 1'b1;
        end else begin
          acc_sum[k] = acc_q[k] + CNT_ONE;
        end
`else
        acc_sum[k] = acc_q[k] + CNT_ONE;
`endif
      end
    end
  end

  // clear wins over everything; a boundary cycle needs en and the last
  // timer value. The edge detected in the boundary cycle goes into the
  // published count so nothing is lost between windows.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q     <= '0;
      ovf_q       <= '0;
      int_cnt_out <= '0;
      ovf         <= '0;
      cnt_valid   <= 1'b0;
      // NOTE: the accumulator array is a handful of registers, not a RAM,
      // so resetting it element by element is intended.
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
    end else begin
      cnt_valid <= 1'b0;
      if (clear) begin
        timer_q <= '0;
        ovf_q   <= '0;
        for (int k = 0; k < NUM_CH; k++) acc_q[k] <= '0;
      end else if (en) begin
        if (timer_q == TMR_LAST) begin
          timer_q   <= '0;
          ovf       <= ovf_q | sat_hit;
          ovf_q     <= '0;
          cnt_valid <= 1'b1;
          for (int k = 0; k < NUM_CH; k++) begin
            int_cnt_out[k*CNT_W +: CNT_W] <= acc_sum[k];
            acc_q[k]                      <= '0;
          end
        end else begin
          timer_q <= timer_q + TMR_ONE;
          ovf_q   <= ovf_q | sat_hit;
          for (int k = 0; k < NUM_CH; k++) acc_q[k] <= acc_sum[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_rate_counter.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_counter
// Scoreboard bench: expected window results (publication cycle and counts)
// are queued as stimulus is planned and popped whenever cnt_valid is seen.
// A second instance with CNT_W=4 exercises saturation / wrap-around.
// ---------------------------------------------------------------------------
module tb_spike_rate_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int WIN    = 100;

`ifdef SPIKE_CNT_SAT_EN
  localparam logic [3:0] SMALL_EXP = 4'd15;
  localparam logic [3:0] SMALL_OVF = 4'b1000;
`else
  localparam logic [3:0] SMALL_EXP = 4'd4;
  localparam logic [3:0] SMALL_OVF = 4'b0000;
`endif

  typedef struct {
    int          cyc;
    logic [31:0] cnt;
    logic [3:0]  ovf;
  } exp_t;

  logic        clk    = 1'b0;
  logic        reset  = 1'b0;
  logic        en     = 1'b0;
  logic        clear  = 1'b0;
  logic [3:0]  spike  = '0;
  logic [3:0]  spike4 = '0;
  logic [31:0] cnt_out;
  logic        cnt_valid;
  logic [3:0]  ovf;
  logic [15:0] cnt4_out;
  logic        cnt4_valid;
  logic [3:0]  ovf4;

  int   cyc;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  spike_rate_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_CYCLES(WIN)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .spike       (spike),
    .int_cnt_out (cnt_out),
    .cnt_valid   (cnt_valid),
    .ovf         (ovf)
  );

  spike_rate_counter #(.NUM_CH(NUM_CH), .CNT_W(4), .WIN_CYCLES(WIN)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clear       (clear),
    .spike       (spike4),
    .int_cnt_out (cnt4_out),
    .cnt_valid   (cnt4_valid),
    .ovf         (ovf4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cyc=%0d)", tag, got, exp, $time, cyc);
    end
  endtask

  function automatic logic [31:0] pk(input int c0, input int c1, input int c2, input int c3);
    return {c3[7:0], c2[7:0], c1[7:0], c0[7:0]};
  endfunction

  task automatic push(input int c, input logic [31:0] cnt);
    exp_t e;
    e.cyc = c;
    e.cnt = cnt;
    e.ovf = 4'b0000;
    sb_q.push_back(e);
  endtask

  // Monitor: every cnt_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (cnt_valid) begin
      check("valid_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("valid_cyc", cyc, mon_e.cyc);
        check("win_cnt", cnt_out, mon_e.cnt);
        check("win_ovf", ovf, mon_e.ovf);
      end
    end
  end

  // Hold reset for a few cycles, check the reset state, release at a negedge.
  task automatic do_reset();
    check("sb_drained", sb_q.size(), 0);
    reset  = 1'b0;
    en     = 1'b0;
    clear  = 1'b0;
    spike  = '0;
    spike4 = '0;
    repeat (3) @(negedge clk);
    check("rst_cnt", cnt_out, 0);
    check("rst_valid", cnt_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_cnt4", cnt4_out, 0);
    reset = 1'b1;
    en    = 1'b1;
  endtask

  initial begin
    // Idle: all-zero windows every 100 cycles.
    do_reset();
    push(100, pk(0, 0, 0, 0));
    push(200, pk(0, 0, 0, 0));
    for (int i = 0; i < 205; i++) @(negedge clk);

    // ch0 10 high / 10 low, ch2 tied high (one edge right after reset).
    do_reset();
    push(100, pk(5, 0, 1, 0));
    push(200, pk(5, 0, 0, 0));
    push(300, pk(5, 0, 0, 0));
    for (int i = 0; i < 305; i++) begin
      spike[0] = (i < 300) && (((i / 10) % 2) == 0);
      spike[2] = 1'b1;
      @(negedge clk);
    end

    // Edges landing exactly on the boundary cycle and one cycle after it.
    do_reset();
    push(100, pk(0, 1, 0, 0));
    push(200, pk(1, 0, 0, 0));
    push(300, pk(0, 1, 0, 0));
    for (int i = 0; i < 305; i++) begin
      spike[1] = (i >= 96 && i < 100) || (i >= 197 && i < 201);
      spike[0] = (i >= 97 && i < 101);
      @(negedge clk);
    end

    // CNT_W=4 instance: 20 edges in one window, then 3 in the next.
    do_reset();
    push(100, pk(0, 0, 0, 0));
    push(200, pk(0, 0, 0, 0));
    for (int i = 0; i < 205; i++) begin
      spike4[3] = (i < 80) ? ((i % 4) < 2) : (i >= 100 && i < 112 && (i % 4) < 2);
      if (i == 100) begin
        check("small_valid0", cnt4_valid, 1);
        check("small_cnt0", cnt4_out, {SMALL_EXP, 12'h000});
        check("small_ovf0", ovf4, SMALL_OVF);
      end
      if (i == 200) begin
        check("small_valid1", cnt4_valid, 1);
        check("small_cnt1", cnt4_out, 16'h3000);
        check("small_ovf1", ovf4, 4'b0000);
      end
      @(negedge clk);
    end

    // clear mid-window, en low for 30 cycles, clear on a boundary cycle.
    do_reset();
    push(151, pk(2, 0, 0, 0));
    push(281, pk(1, 0, 0, 0));
    push(481, pk(0, 0, 1, 0));
    for (int i = 0; i < 485; i++) begin
      spike[0] = (i inside {[10:11], [20:21], [30:31], [60:61], [70:71],
                            [165:166], [175:176], [185:186], [200:201]});
      spike[1] = (i >= 170 && i < 480);
      spike[2] = (i inside {[300:301], [400:401]});
      clear    = (i == 50) || (i == 380);
      en       = !(i >= 160 && i < 190);
      if (i == 180) check("hold_en_low", cnt_out, pk(2, 0, 0, 0));
      if (i == 381) begin
        check("hold_clear_cnt", cnt_out, pk(1, 0, 0, 0));
        check("clear_no_valid", cnt_valid, 0);
      end
      @(negedge clk);
    end
    en    = 1'b1;
    clear = 1'b0;
    spike = '0;

    // Reset asserted mid-window (timer=60) with nonzero outputs.
    do_reset();
    push(100, pk(0, 0, 0, 1));
    for (int i = 0; i < 160; i++) begin
      spike[3] = (i >= 5 && i < 8);
      @(negedge clk);
    end
    check("pre_reset_cnt", cnt_out, pk(0, 0, 0, 1));
    #2 reset = 1'b0;
    #1;
    check("async_rst_cnt", cnt_out, 0);
    check("async_rst_valid", cnt_valid, 0);
    check("async_rst_ovf", ovf, 0);
    @(negedge clk);
    do_reset();
    push(100, pk(0, 0, 0, 0));
    for (int i = 0; i < 105; i++) @(negedge clk);

    check("sb_drained_end", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
